// File: rtl/md_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package md_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    function automatic logic is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return !((op == MD_MULTU) || (op == MD_DIVU));
    endfunction

endpackage

// File: rtl/md_iter_datapath.sv
// Shared accumulator for radix-2 shift-add multiply and restoring divide.
// Upper half is the partial product / remainder, lower half the multiplier / quotient.
module md_iter_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 div_mode,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_next;

    // One iteration; a successful subtract always fits in WIDTH bits since rem < divisor.
    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;
        if (div_mode) begin
            acc_next = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a_mag};
            opnd <= b_mag;
        end else if (step) begin
            acc  <= acc_next;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide engine owning HI/LO: control FSM, sign fix-up and HI/LO writes.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    md_state_t        state;
    logic [1:0]       op_q;
    logic             neg_q;
    logic             neg_r;
    logic [CNT_W-1:0] cnt;
    logic [W2-1:0]    acc;

    logic             signed_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             zero_div_c;
    logic             load_c;
    logic             step_c;
    logic             fix_signed_c;
    logic [W2-1:0]    prod_c;
    logic [WIDTH-1:0] quot_c;
    logic [WIDTH-1:0] rem_c;

    // Operand magnitudes on issue, signed results at FIX.
    always_comb begin
        signed_c     = is_signed_op(op);
        a_mag_c      = (signed_c && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
        b_mag_c      = (signed_c && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
        zero_div_c   = is_div(op) && (b == '0);
        load_c       = ((state == MD_IDLE) || (state == MD_DONE)) && start && !zero_div_c;
        step_c       = (state == MD_RUN);
        fix_signed_c = is_signed_op(op_q);
        prod_c       = (fix_signed_c && neg_q) ? (~acc + W2'(1)) : acc;
        quot_c       = (fix_signed_c && neg_q) ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_c        = (fix_signed_c && neg_r) ? (~acc[W2-1:WIDTH] + WIDTH'(1)) : acc[W2-1:WIDTH];
    end

    md_iter_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clock    (clock),
        .reset    (reset),
        .load     (load_c),
        .step     (step_c),
        .div_mode (is_div(op_q)),
        .a_mag    (a_mag_c),
        .b_mag    (b_mag_c),
        .acc      (acc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= MD_IDLE;
            op_q     <= MD_MULT;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE, MD_DONE: begin
                    if (hi_wr) hi <= wr_data;
                    if (lo_wr) lo <= wr_data;
                    state <= MD_IDLE;
                    if (start) begin
                        op_q  <= op;
                        neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        neg_r <= a[WIDTH-1];
                        cnt   <= '0;
                        if (zero_div_c) begin
                            div_zero <= 1'b1;
                            done     <= 1'b1;
                            state    <= MD_DONE;
                        end else begin
                            div_zero <= 1'b0;
                            busy     <= 1'b1;
                            state    <= MD_RUN;
                        end
                    end
                end
                MD_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    if (is_div(op_q)) begin
                        hi <= rem_c;
                        lo <= quot_c;
                    end else begin
                        hi <= prod_c[W2-1:WIDTH];
                        lo <= prod_c[WIDTH-1:0];
                    end
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= MD_DONE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised bench for mult_div_unit (WIDTH=32) against a transaction-level arithmetic model.
module tb_mult_div_unit;

    localparam int unsigned W = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          hi_wr;
    logic          lo_wr;
    logic [W-1:0]  wr_data;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int n_assert = 0;
    int n_fail   = 0;
    logic chk_en;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of one operation, straight from integer arithmetic.
    function automatic void model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                         output logic [31:0] rh, output logic [31:0] rl);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00:   p = 64'(sx * sy);
            2'b01:   p = {32'b0, x} * {32'b0, y};
            2'b10:   begin q = sx / sy; r = sx % sy; p = {32'(r), 32'(q)}; end
            default: p = {x % y, x / y};
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    // Model state: remaining busy cycles, pending result, visible registers.
    logic [31:0] m_hi, m_lo, r_hi, r_lo;
    logic        m_dz, m_done;
    int          m_left;

    always @(posedge clock) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_hi = r_hi; m_lo = r_lo; m_done = 1'b1;
                end
            end else begin
                if (hi_wr) m_hi = wr_data;
                if (lo_wr) m_lo = wr_data;
                if (start) begin
                    m_dz = 1'b0;
                    if (op[1] && b == 0) begin
                        m_dz = 1'b1; m_done = 1'b1;
                    end else begin
                        model_result(op, a, b, r_hi, r_lo);
                        m_left = W + 1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("busy", busy, m_left > 0);
            check("done", done, m_done);
            check("div_zero", div_zero, m_dz);
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    // Issue one op at the current negedge; returns at the negedge of the done cycle.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int inj_at, output int lat, output int nbusy);
        int n;
        n = 0; lat = -1; nbusy = 0;
        op = o; a = x; b = y; start = 1'b1;
        while (lat < 0 && n < 100) begin
            @(negedge clock);
            n++;
            start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
            op = 2'($urandom); a = $urandom; b = $urandom;
            if (n == inj_at) begin
                start = 1'b1; op = 2'b10; b = 32'd1; hi_wr = 1'b1; wr_data = 32'hAA;
            end
            if (busy) nbusy++;
            if (done) lat = n;
        end
        if (lat < 0) begin
            n_assert++; n_fail++;
            $display("FAIL done_timeout: no done within %0d cycles", n);
        end
    endtask

    task automatic run_lit(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] eh, input logic [31:0] el, input int elat);
        int lat, nb;
        do_op(o, x, y, 0, lat, nb);
        check("latency", lat, elat);
        check("busy_cycles", nb, (elat == 1) ? 0 : elat - 1);
        check("lit_hi", hi, eh);
        check("lit_lo", lo, el);
        check("model_hi", m_hi, eh);
        check("model_lo", m_lo, el);
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nb;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        clock = 1'b0; reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0; chk_en = 1'b0;
        @(negedge clock);
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dz", div_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        reset = 1'b0;
        @(negedge clock);

        run_lit(md_pkg::MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34);
        run_lit(md_pkg::MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);
        run_lit(md_pkg::MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         34);
        run_lit(md_pkg::MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        run_lit(md_pkg::MD_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         34);
        run_lit(md_pkg::MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 34);

        // Divide by zero leaves HI/LO alone; next accepted start clears the flag.
        hi_wr = 1'b1; wr_data = 32'h11;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 32'h22;
        @(negedge clock);
        lo_wr = 1'b0;
        run_lit(md_pkg::MD_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 1);
        check("dz_held", div_zero, 1);
        run_lit(md_pkg::MD_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 34);
        check("dz_cleared", div_zero, 0);

        // start/hi_wr during RUN are ignored.
        do_op(md_pkg::MD_MULTU, 32'd3, 32'd4, 5, lat, nb);
        check("busy_start_lat", lat, 34);
        check("busy_start_hi", hi, 0);
        check("busy_start_lo", lo, 12);
        @(negedge clock);
        hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h55;
        @(negedge clock);
        hi_wr = 1'b0; lo_wr = 1'b0;
        check("wr_hi", hi, 32'h55);
        check("wr_lo", lo, 32'h55);

        // Reset in cycle 10 of a MULT aborts cleanly.
        op = md_pkg::MD_MULT; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        run_lit(md_pkg::MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 34);

        // Random operations, back-to-back starts from DONE, writes coinciding with start.
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = pick();
            rb = pick();
            hi_wr = 1'($urandom_range(0, 3) == 0);
            lo_wr = 1'($urandom_range(0, 3) == 0);
            wr_data = $urandom;
            do_op(ro, ra, rb, 0, lat, nb);
            check("rand_latency", lat, (ro[1] && rb == 0) ? 1 : 34);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                hi_wr = 1'($urandom_range(0, 1));
                wr_data = $urandom;
                @(negedge clock);
                hi_wr = 1'b0;
            end
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide engine that owns the HI/LO register pair of the multicycle CPU.
- The control unit issues a start pulse with an opcode and waits for a one-cycle done pulse.
- Generalises the current fixed 32-bit MULT/DIV pair with:
  - signed and unsigned modes;
  - a configurable operand width;
  - direct HI/LO writes;
  - divide-by-zero reporting.
- Sits beside the ALU in the datapath; operands come from A/B registers, results feed the HI/LO read muxes.

Parameters:
- WIDTH, 32, operand width in bits (>=4); HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request operation; sampled only in IDLE or DONE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend
- b  in  WIDTH  multiplier / divisor
- hi_wr  in  1  load hi from wr_data (mthi)
- lo_wr  in  1  load lo from wr_data (mtlo)
- wr_data  in  WIDTH  direct-write data
- busy  out  1  high in RUN and FIX
- done  out  1  one-cycle completion pulse
- div_zero  out  1  last DIV/DIVU had b==0; held until next accepted start
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Reset values:
  - state=IDLE; busy=0; done=0; div_zero=0; hi=0; lo=0; counter=0.
  - Reset mid-operation aborts the operation identically; no partial result is written.
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start (cycle 0):
  - At the cycle-0 edge, latch op and operand magnitudes |a|, |b|; take the absolute value only for signed ops.
  - Record neg_q = sign(a)^sign(b) and neg_r = sign(a).
  - Clear div_zero; counter=0.
  - If op is DIV/DIVU and b==0: go to DONE, div_zero=1, hi/lo unchanged. done is seen in cycle 1.
  - Otherwise go to RUN.
- RUN, one iteration per cycle, WIDTH cycles (counter 0..WIDTH-1):
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing a WIDTH-bit quotient and remainder.
  - After the last iteration, go to FIX.
- FIX, one cycle; writes hi/lo at its closing edge:
  - Multiply: product negated (2*WIDTH two's complement) if signed and neg_q; hi=upper half, lo=lower half.
  - Divide: lo=quotient, negated if signed and neg_q; hi=remainder, negated if signed and neg_r.
  - Next state DONE.
- DONE: done=1 for exactly this cycle.
  - Next state is IDLE, or a new operation if start is asserted.
- Latency: start in cycle 0 -> done in cycle WIDTH+2 (34 for WIDTH=32); hi/lo valid in the same cycle as done.
- start during RUN/FIX is ignored; no queueing.
- The op input is don't-care when start=0.
- Signed DIV of the most-negative value by -1: quotient=most-negative value, remainder=0. No trap; this falls out of magnitude arithmetic truncated to WIDTH.
- hi_wr/lo_wr:
  - Accepted in IDLE/DONE only; ignored while busy.
  - If hi_wr/lo_wr coincides with an accepted start, the write still occurs and is later overwritten at FIX.
  - hi_wr and lo_wr may both be high; both load wr_data.
- Magnitude of the most-negative signed operand is 2^(WIDTH-1), held in WIDTH unsigned bits.

Decomposition:
- Package md_pkg holds:
  - op encoding localparams (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - state enum (MD_IDLE, MD_RUN, MD_FIX, MD_DONE);
  - helper function is_div(op).
- One sub-module, md_iter_datapath: registers for accumulator/remainder/quotient and the per-iteration step.
  - Controlled by load/step/mode inputs; parametrised by WIDTH.
- FSM, sign correction, HI/LO registers and handshake stay in mult_div_unit.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at cycle 0 -> done only in cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- MULT a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7 b=2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV a=5 b=0 after hi=0x11, lo=0x22 -> done in cycle 1, div_zero=1, hi/lo unchanged; a following MULTU 2*3 clears div_zero at its start, giving lo=6, hi=0.
- Start MULTU 3*4; at cycle 5 pulse start (DIV), hi_wr, wr_data=0xAA -> both ignored; result lo=12, hi=0. Then hi_wr=lo_wr=1, wr_data=0x55 in IDLE -> hi=lo=0x55 next cycle.
- Start MULT, assert reset in cycle 10 -> next cycle busy=0, done=0, hi=lo=0, state IDLE; a new start in the following cycle completes normally 34 cycles later.
